bin_to_digits: RTL
==================

Name: bin_to_digits

Overview:
- Sequential binary-to-decimal encoder that produces 5-bit digit codes for the sevensegment display driver (dig0..dig7 inputs).
- Converts a binary value such as compass_val (heading 0-359) to decimal with a one-bit-per-cycle double-dabble shifter.
- Sits between the RojoBot outputs and the sevensegment instance in the top level.
- Start/busy/done handshake; result is held until the next conversion.

Parameters:
- BIN_WIDTH, 12, width of the binary input (1..16).
- NUM_DIGITS, 4, number of decimal digits produced (1..5).

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request conversion; sampled only in IDLE.
- bin_in  in  BIN_WIDTH  unsigned value; captured on the accepted start edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when dig_out is updated.
- overflow  out  1  last result exceeded 10^NUM_DIGITS-1.
- dig_out  out  5*NUM_DIGITS  digit codes; [4:0]=units, higher slices = higher decades.

Behaviour:
- Reset (reset==0 at a clk edge), from any state including mid-conversion:
  - state=IDLE, busy=0, done=0, overflow=0.
  - dig_out units=5'h00 ('0'); all other digits=CHAR_BLANK.
  - Shift register and counter cleared.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - start=1 at edge E0: load shift reg {BCD=0, bin_in}, counter=BIN_WIDTH, go to SHIFT, busy=1 from E0.
  - start=0: stay in IDLE.
- SHIFT:
  - Each edge: every BCD nibble >=5 gets +3 (combinational), then shift left 1 and decrement counter.
  - Carry out of the top nibble sets a sticky ovf bit.
  - Counter reaches 0 after BIN_WIDTH edges (E1..E_BIN_WIDTH); then go to FINISH.
- FINISH (edge E_BIN_WIDTH+1):
  - Register dig_out from the BCD nibbles ({1'b0,nibble}).
  - overflow=ovf. If overflow=1, every digit=CHAR_DASH.
  - done=1 for exactly this cycle, busy=0, return to IDLE.
- Latency: start accepted to done high = BIN_WIDTH+1 cycles (13 at default).
- start while busy=1: ignored, no queuing; bin_in changes mid-conversion have no effect.
- start=1 in the cycle done=1: accepted, since the state is already IDLE. Back-to-back period = BIN_WIDTH+2 cycles.
- start held high continuously: the block reconverts repeatedly.
- dig_out and overflow change only at FINISH or reset; they are stable otherwise.
- Input 0: units digit '0'; the units digit is never blanked.

Optional Feature:
- Macro: BIN_TO_DIGITS_LZ_BLANK_EN.
- Defined: leading-zero blanking. Zero digits above the most-significant nonzero digit output CHAR_BLANK; the units digit is always shown.
- Undefined: all NUM_DIGITS digits are shown, including leading zeros.
- Overflow dash display is the same in both builds.

Decomposition:
- Package digit_codes_pkg:
  - DIG_W=5.
  - CHAR_BLANK=5'h1F and CHAR_DASH=5'h1E, matching the sevensegment special codes.
  - State encoding enum {IDLE, SHIFT, FINISH}.
  - Function for the counter width, clog2(BIN_WIDTH+1).
- One sub-module: dd_add3, a combinational 4-bit "if >=5 add 3" cell, instantiated NUM_DIGITS times via generate.

Test Plan:
- Reset: hold reset=0 for 3 clk -> busy=0, done=0, overflow=0, dig_out={1F,1F,1F,00}.
- Conversion: bin_in=359, start 1 cycle -> done exactly 13 cycles later.
  - With LZ_BLANK_EN: dig_out={1F,03,05,09}.
  - Without: dig_out={00,03,05,09}.
- Max and zero: bin_in=4095 -> {04,00,09,05}, overflow=0. bin_in=0 -> units=00; upper digits=1F with LZ_BLANK_EN, 00 without.
- Overflow: NUM_DIGITS=3, bin_in=1000 -> overflow=1, dig_out={1E,1E,1E}. Next conversion of 999 -> overflow=0, {09,09,09}.
- Handshake:
  - Pulse start=1 with bin_in=100 at cycles 0 and 5 -> one done only, at cycle 13, result 100.
  - Then start in the done cycle with bin_in=42 -> second done at cycle 27, result 42.
- Reset mid-conversion: reset=0 at cycle 6 of a 359 conversion -> no done; reset outputs on the next edge. A new start afterwards converts correctly.

Source files
------------

// File: rtl/digit_codes_pkg.sv
// Shared digit codes, FSM state encoding and sizing helper for bin_to_digits.
package digit_codes_pkg;

  localparam int unsigned DIG_W = 5;

  // Special codes understood by the sevensegment driver
  localparam logic [DIG_W-1:0] CHAR_BLANK = 5'h1F;
  localparam logic [DIG_W-1:0] CHAR_DASH  = 5'h1E;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Bits needed for a down-counter that is loaded with bin_width
  function automatic int unsigned cnt_width(input int unsigned bin_width);
    return $clog2(bin_width + 1);
  endfunction

endpackage

// File: rtl/bin_to_digits_dd_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the shift.
module dd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib_c
);

  // Nibbles 5..9 become 8..12 so the following left shift carries into the next decade
  always_comb begin
    o_nib_c = i_nib;
    if (i_nib >= 4'd5) begin
      o_nib_c = i_nib + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_digits.sv
// Sequential binary-to-decimal encoder feeding the sevensegment digit inputs.
// One bit per clock double-dabble; result held until the next conversion.
// Optional macro BIN_TO_DIGITS_LZ_BLANK_EN: blank leading zero digits (units always shown).
module bin_to_digits
  import digit_codes_pkg::*;
#(
  parameter int unsigned BIN_WIDTH  = 12,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [BIN_WIDTH-1:0]        bin_in,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [DIG_W*NUM_DIGITS-1:0] dig_out
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned SH_W  = BCD_W + BIN_WIDTH;
  localparam int unsigned CNT_W = cnt_width(BIN_WIDTH);

  state_e                      r_state;
  logic [SH_W-1:0]             r_shift;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_ovf;

  logic [BCD_W-1:0]            w_bcd_adj;
  logic [SH_W-1:0]             w_shift_adj;
  logic [DIG_W*NUM_DIGITS-1:0] w_digits;
  logic [DIG_W*NUM_DIGITS-1:0] w_rst_digits;
`ifdef BIN_TO_DIGITS_LZ_BLANK_EN
  logic                        w_lead;
`endif

  // One add-3 cell per decade, operating on the BCD part of the shift register
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    dd_add3 u_add3 (
      .i_nib   (r_shift[BIN_WIDTH + 4*g +: 4]),
      .o_nib_c (w_bcd_adj[4*g +: 4])
    );
  end

  assign w_shift_adj = {w_bcd_adj, r_shift[BIN_WIDTH-1:0]};

  // Idle display pattern: '0' in the units position, blanks above
  always_comb begin
    w_rst_digits = '0;
    for (int i = 1; i < int'(NUM_DIGITS); i++) begin
      w_rst_digits[DIG_W*i +: DIG_W] = CHAR_BLANK;
    end
  end

  // Digit codes presented at FINISH: dashes on overflow, otherwise {0,nibble}
  always_comb begin
    w_digits = '0;
`ifdef BIN_TO_DIGITS_LZ_BLANK_EN
    w_lead   = 1'b1;
`endif
    if (r_ovf) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        w_digits[DIG_W*i +: DIG_W] = CHAR_DASH;
      end
    end else begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        w_digits[DIG_W*i +: DIG_W] = {1'b0, r_shift[BIN_WIDTH + 4*i +: 4]};
      end
`ifdef BIN_TO_DIGITS_LZ_BLANK_EN
      // Walk down from the top decade; blank zeros until the first nonzero digit
      for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
        if (w_lead && (r_shift[BIN_WIDTH + 4*i +: 4] == 4'd0)) begin
          w_digits[DIG_W*i +: DIG_W] = CHAR_BLANK;
        end else begin
          w_lead = 1'b0;
        end
      end
`endif
    end
  end

  // Conversion FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      dig_out  <= w_rst_digits;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift <= {{BCD_W{1'b0}}, bin_in};
            r_cnt   <= CNT_W'(BIN_WIDTH);
            r_ovf   <= 1'b0;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          // The adjusted top nibble's MSB leaves the register: a lost decade
          r_ovf   <= r_ovf | w_bcd_adj[BCD_W-1];
          r_shift <= {w_shift_adj[SH_W-2:0], 1'b0};
          r_cnt   <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= FINISH;
          end
        end
        FINISH: begin
          dig_out  <= w_digits;
          overflow <= r_ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
